// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for the MEM stage of the RV32I core.
// It services one load or store at a time against an internal word-organised
// RAM. Each access takes a fixed number of wait states, and the pipeline is
// stalled until the access completes.
//
// Ports:
//   clk, rst    rising-edge clock; asynchronous active-high reset
//   MemReadM    load request (held stable while StallMem=1)
//   MemWriteM   store request (held stable while StallMem=1)
//   ALUResultM  byte address
//   WriteDataM  store data (low byte/half used for SB/SH)
//   funct3M     RV32I load/store size and sign encoding
//   Data_Out    extended load result; valid only in DONE, otherwise 0
//   StallMem    stall the front of the pipeline; bubble into MEM/WB
//   MisalignM   one-cycle flag in DONE for a misaligned access
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [2:0]  funct3M,
  output logic [31:0] Data_Out,
  output logic        StallMem,
  output logic        MisalignM
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [31:0] rdata_q;
  logic        mis_q;
  logic [31:0] mem [DEPTH_WORDS];

  logic          req;
  logic          is_load;
  logic          misalign;
  logic          commit;
  logic [AW-1:0] idx;
  logic [3:0]    be;
  logic [31:0]   wdata;
  logic          unused_addr;

  // Sign/zero extension of the addressed lane. Misaligned and undefined
  // encodings are filtered out by the caller / return 0 here.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [2:0]  f3,
                                              input logic [1:0]  off);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = $signed(word[8*off +: 8]);
    h = $signed(word[16*off[1] +: 16]);
    case (f3)
      3'b000:  load_extend = 32'($signed(b));
      3'b001:  load_extend = 32'($signed(h));
      3'b010:  load_extend = word;
      3'b100:  load_extend = {24'd0, b};
      3'b101:  load_extend = {16'd0, h};
      default: load_extend = 32'd0;
    endcase
  endfunction

  function automatic logic [3:0] store_enable(input logic [2:0] f3,
                                              input logic [1:0] off);
    case (f3)
      3'b000:  store_enable = 4'b0001 << off;
      3'b001:  store_enable = off[1] ? 4'b1100 : 4'b0011;
      3'b010:  store_enable = 4'b1111;
      default: store_enable = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0]  f3,
                                             input logic [31:0] wd);
    case (f3)
      3'b000:  store_data = {4{wd[7:0]}};
      3'b001:  store_data = {2{wd[15:0]}};
      default: store_data = wd;
    endcase
  endfunction

  assign req     = MemReadM | MemWriteM;
  // A simultaneous read+write is treated as a store and returns no data.
  assign is_load = MemReadM & ~MemWriteM;
  assign idx     = ALUResultM[AW+1:2];
  assign misalign = (((funct3M == 3'b001) || (funct3M == 3'b101)) && ALUResultM[0])
                 || ((funct3M == 3'b010) && (ALUResultM[1:0] != 2'b00));
  assign commit  = (state == WAIT) && (cnt == 4'd0);
  assign be      = store_enable(funct3M, ALUResultM[1:0]);
  assign wdata   = store_data(funct3M, WriteDataM);
  assign unused_addr = ^ALUResultM[31:AW+2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      rdata_q <= 32'd0;
      mis_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      // The extended result is captured here, so Data_Out has no path from inputs.
      if (commit) begin
        rdata_q <= (is_load && !misalign)
                   ? load_extend(mem[idx], funct3M, ALUResultM[1:0]) : 32'd0;
        mis_q   <= misalign;
      end
    end
  end

  // RAM is not reset. Reset forces state to IDLE, so commit drops a pending store.
  always_ff @(posedge clk) begin
    if (commit && MemWriteM && !misalign) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (req) begin
          cnt_nxt   = CNT_INIT;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (cnt == 4'd0) state_nxt = DONE;
        else             cnt_nxt   = cnt - 4'd1;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign StallMem  = ~rst & (((state == IDLE) & req) | (state == WAIT));
  assign Data_Out  = (state == DONE) ? rdata_q : 32'd0;
  assign MisalignM = (state == DONE) & mis_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: drives load/store transactions and pushes
// the expected result of each one to a scoreboard queue. A negedge monitor
// pops the queue on each DONE cycle and compares the outputs.
module tb_dmem_responder;

  localparam int LAT = 2;
  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        MemReadM = 1'b0;
  logic        MemWriteM = 1'b0;
  logic [31:0] ALUResultM = 32'd0;
  logic [31:0] WriteDataM = 32'd0;
  logic [2:0]  funct3M = 3'd0;
  logic [31:0] Data_Out;
  logic        StallMem;
  logic        MisalignM;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int stall_cnt = 0;
  logic        prev_stall = 1'b0;
  logic [36:0] prev_ctl = '0;
  logic [31:0] prev_wd = '0;
  logic [32:0] sb[$];

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .funct3M(funct3M),
    .Data_Out(Data_Out), .StallMem(StallMem), .MisalignM(MisalignM));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Monitor: counts stall cycles, detects DONE (first non-stall cycle after a
  // stall) and compares against the scoreboard head.
  initial begin
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_cnt  = 0;
        prev_stall = 1'b0;
      end else begin
        if (StallMem) begin
          if (prev_stall) begin
            chk("proto_ctl", 64'({MemReadM, MemWriteM, funct3M, ALUResultM}), 64'(prev_ctl));
            chk("proto_wd", 64'(WriteDataM), 64'(prev_wd));
          end
          stall_cnt++;
          chk("out_quiet", 64'({MisalignM, Data_Out}), 64'd0);
        end else if (stall_cnt > 0) begin
          chk("stall_len", 64'(stall_cnt), 64'(LAT + 1));
          chk("sb_nonempty", 64'(sb.size() > 0), 64'd1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("data_out", 64'(Data_Out), 64'(e[31:0]));
            chk("misalign", 64'(MisalignM), 64'(e[32]));
          end
          stall_cnt = 0;
          done_cnt++;
        end else begin
          chk("out_quiet", 64'({MisalignM, Data_Out}), 64'd0);
        end
        prev_stall = StallMem;
        prev_ctl   = {MemReadM, MemWriteM, funct3M, ALUResultM};
        prev_wd    = WriteDataM;
      end
    end
  end

  // Call at posedge+1 with the FSM in IDLE; returns at posedge+1 after DONE.
  task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [2:0] f3,
                        input logic [31:0] exp_d, input logic exp_m);
    int start;
    start = done_cnt;
    sb.push_back({exp_m, exp_d});
    MemReadM = rd; MemWriteM = wr; ALUResultM = addr; WriteDataM = wd; funct3M = f3;
    for (int i = 0; i < 40 && done_cnt == start; i++) begin
      @(negedge clk); #1;
    end
    chk("timeout", 64'(done_cnt - start), 64'd1);
    @(posedge clk); #1;
    MemReadM = 1'b0; MemWriteM = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_stall", 64'(StallMem), 64'd0);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", 64'({StallMem, MisalignM, Data_Out}), 64'd0);
    rst = 1'b0;
    idle(10);

    access(0, 1, 32'h10, 32'hDEADBEEF, 3'b010, 32'h0, 0);
    access(1, 0, 32'h10, 32'h0, 3'b010, 32'hDEADBEEF, 0);
    access(1, 0, 32'h13, 32'h0, 3'b000, 32'hFFFFFFDE, 0);
    access(1, 0, 32'h13, 32'h0, 3'b100, 32'h000000DE, 0);
    access(1, 0, 32'h10, 32'h0, 3'b001, 32'hFFFFBEEF, 0);
    access(1, 0, 32'h12, 32'h0, 3'b101, 32'h0000DEAD, 0);

    access(0, 1, 32'h11, 32'h00000055, 3'b000, 32'h0, 0);
    access(1, 0, 32'h10, 32'h0, 3'b010, 32'hDEAD55EF, 0);
    access(0, 1, 32'h12, 32'h00001234, 3'b001, 32'h0, 0);
    access(1, 0, 32'h10, 32'h0, 3'b010, 32'h123455EF, 0);
    // Address wraps modulo 4*DEPTH.
    access(1, 0, 32'h10 + 4 * DEPTH, 32'h0, 3'b010, 32'h123455EF, 0);

    access(0, 1, 32'h14, 32'hCAFEF00D, 3'b010, 32'h0, 0);
    access(0, 1, 32'h16, 32'h99999999, 3'b010, 32'h0, 1);
    access(1, 0, 32'h14, 32'h0, 3'b010, 32'hCAFEF00D, 0);
    access(1, 0, 32'h13, 32'h0, 3'b001, 32'h0, 1);

    // Read and write together: handled as a store, no data returned.
    access(1, 1, 32'h18, 32'h0BADF00D, 3'b010, 32'h0, 0);
    access(1, 0, 32'h18, 32'h0, 3'b010, 32'h0BADF00D, 0);

    // Store aborted by reset during WAIT must not reach the RAM.
    access(0, 1, 32'h20, 32'h11223344, 3'b010, 32'h0, 0);
    MemWriteM = 1'b1; ALUResultM = 32'h20; WriteDataM = 32'hA5A5A5A5; funct3M = 3'b010;
    @(posedge clk); #2;
    rst = 1'b1; MemWriteM = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_out", 64'({StallMem, MisalignM, Data_Out}), 64'd0);
    rst = 1'b0;
    idle(5);
    access(1, 0, 32'h20, 32'h0, 3'b010, 32'h11223344, 0);
    access(1, 0, 32'h10, 32'h0, 3'b100, 32'h000000EF, 0);
    idle(3);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
